// File: rtl/gcd_host_sequencer.sv
// gcd_host_sequencer: host-side driver for the subtractive GCD core.
// Accepts an operand pair, loads A (with start) and then B over the core's
// shared data bus, waits for done (bounded by a timeout), returns the result,
// and then pulses the core's local reset, because the core's done state is
// terminal and the core must be re-armed before the next pair.
module gcd_host_sequencer #(
  parameter int WIDTH      = 8,
  parameter int TIMEOUT    = 1024,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic [WIDTH-1:0] gcd_data,
  output logic             gcd_start,
  output logic             gcd_rst_n,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(RST_CYCLES + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_SAT  = TW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_INIT   = CW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    WAIT,
    RESP,
    CORE_RST
  } state_t;

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] a_reg,      a_next;
  logic [WIDTH-1:0] b_reg,      b_next;
  logic [TW-1:0]    timer_reg,  timer_next;
  logic [CW-1:0]    cnt_reg,    cnt_next;
  logic             bypass_reg, bypass_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             err_reg,    err_next;

  // State and datapath registers; reset parks in CORE_RST so the core is
  // always re-armed after a host reset, even one that lands mid-transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= CORE_RST;
      a_reg      <= '0;
      b_reg      <= '0;
      timer_reg  <= '0;
      cnt_reg    <= CNT_INIT;
      bypass_reg <= 1'b0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      timer_reg  <= timer_next;
      cnt_reg    <= cnt_next;
      bypass_reg <= bypass_next;
      result_reg <= result_next;
      err_reg    <= err_next;
    end
  end

  // Next-state and datapath update for the single transaction in flight.
  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    timer_next  = timer_reg;
    cnt_next    = cnt_reg;
    bypass_next = bypass_reg;
    result_next = result_reg;
    err_next    = err_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next = in_a;
          b_next = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            // The core never terminates on a zero operand; answer locally.
            result_next = in_a | in_b;
            err_next    = 1'b0;
            bypass_next = 1'b1;
            state_next  = RESP;
          end else begin
            bypass_next = 1'b0;
            state_next  = LOAD_A;
          end
        end
      end
      LOAD_A: begin
        state_next = LOAD_B;
      end
      LOAD_B: begin
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (gcd_done) begin
          result_next = gcd_result;
          err_next    = 1'b0;
          state_next  = RESP;
        end else if (timer_reg == TIMER_LAST) begin
          result_next = '0;
          err_next    = 1'b1;
          state_next  = RESP;
        end else if (timer_reg != TIMER_SAT) begin
          timer_next = timer_reg + 1'b1;
        end
      end
      RESP: begin
        if (out_ready) begin
          if (bypass_reg) begin
            state_next = IDLE;
          end else begin
            cnt_next   = CNT_INIT;
            state_next = CORE_RST;
          end
        end
      end
      CORE_RST: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = CORE_RST;
        cnt_next   = CNT_INIT;
      end
    endcase
  end

  // Core bus: A while loading A, B from LOAD_B through the wait, idle-low otherwise.
  always_comb begin
    gcd_data = '0;
    case (state_reg)
      LOAD_A:       gcd_data = a_reg;
      LOAD_B, WAIT: gcd_data = b_reg;
      default:      gcd_data = '0;
    endcase
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == RESP);
  assign out_result = result_reg;
  assign out_err    = err_reg;
  assign gcd_start  = (state_reg == LOAD_A);
  assign gcd_rst_n  = (state_reg != CORE_RST);

endmodule

// File: tb/tb_gcd_host_sequencer.sv
// tb_gcd_host_sequencer: directed vectors for the GCD host sequencer, driving
// a small behavioural model of the subtractive GCD core on the core-side bus.
module tb_gcd_host_sequencer;

  localparam int WIDTH      = 8;
  localparam int TIMEOUT    = 16;
  localparam int RST_CYCLES = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_err;
  logic [WIDTH-1:0] gcd_data;
  logic             gcd_start;
  logic             gcd_rst_n;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_result;

  int n_vec = 0;
  int n_err = 0;
  int start_pulses = 0;

  // Core model state
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [1:0]       core_phase;
  logic             core_done;
  logic             stuck_done;

  always #5 clk = ~clk;

  gcd_host_sequencer #(
    .WIDTH      (WIDTH),
    .TIMEOUT    (TIMEOUT),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .gcd_data   (gcd_data),
    .gcd_start  (gcd_start),
    .gcd_rst_n  (gcd_rst_n),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result)
  );

  // Behavioural subtractive GCD core: A captured on start, B the cycle after,
  // then one subtraction per cycle until equal; done is terminal until reset.
  always @(posedge clk) begin
    if (!gcd_rst_n) begin
      core_phase <= 2'd0;
      core_done  <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
    end else begin
      case (core_phase)
        2'd0: if (gcd_start) begin
          core_a     <= gcd_data;
          core_phase <= 2'd1;
        end
        2'd1: begin
          core_b     <= gcd_data;
          core_phase <= 2'd2;
        end
        2'd2: begin
          if (core_a == core_b) begin
            if (!stuck_done) begin
              core_done  <= 1'b1;
              core_phase <= 2'd3;
            end
          end else if (core_a > core_b) begin
            core_a <= core_a - core_b;
          end else begin
            core_b <= core_b - core_a;
          end
        end
        default: ;
      endcase
    end
  end

  assign gcd_done   = core_done;
  assign gcd_result = core_a;

  // Count start strobes seen by the core.
  always @(posedge clk) begin
    if (gcd_start) start_pulses <= start_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction: handshake, core load, result, optional backpressure,
  // then the core re-arm pulse (or none, for a zero-operand bypass).
  task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_res, input logic exp_err,
                         input int exp_lat, input bit bypass, input int hold);
    int lat;
    int n;
    int starts0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_pre", in_ready, 1);
    starts0  = start_pulses;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    check("in_ready_busy", in_ready, 0);
    if (!bypass) begin
      check("ld_a_start", gcd_start, 1);
      check("ld_a_data", gcd_data, a);
      @(posedge clk); #1;
      lat = 1;
      check("ld_b_start", gcd_start, 0);
      check("ld_b_data", gcd_data, b);
    end else begin
      check("bypass_rst_n", gcd_rst_n, 1);
    end
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid", out_valid, 1);
    check("latency", lat, exp_lat);
    check("result", out_result, exp_res);
    check("err", out_err, exp_err);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", out_result, exp_res);
      check("hold_err", out_err, exp_err);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    if (!bypass) begin
      n = 0;
      while (!gcd_rst_n && n < 20) begin
        check("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        n++;
      end
      check("core_rst_len", n, RST_CYCLES);
    end else begin
      check("bypass_rst_n_end", gcd_rst_n, 1);
    end
    in_valid = 1'b0;
    check("start_pulses", start_pulses - starts0, bypass ? 0 : 1);
    check("in_ready_back", in_ready, 1);
    $display("txn a=%0d b=%0d -> result=%0d err=%0d latency=%0d hold=%0d",
             a, b, exp_res, exp_err, lat, hold);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b0;
    stuck_done = 1'b0;

    // Power-on reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_err", out_err, 0);
    check("rst_gcd_data", gcd_data, 0);
    check("rst_gcd_start", gcd_start, 0);
    check("rst_gcd_rst_n", gcd_rst_n, 0);
    rst_n = 1'b1;
    n = 0;
    while (!gcd_rst_n && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("init_rst_len", n, RST_CYCLES);
    check("init_in_ready", in_ready, 1);
    $display("reset released, core re-armed after %0d cycles", n);

    // Normal pairs: latency = 4 + number of subtractions
    run_txn(8'd48, 8'd18, 8'd6, 1'b0, 8, 1'b0, 0);
    run_txn(8'd7,  8'd7,  8'd7, 1'b0, 4, 1'b0, 0);
    // Zero-operand bypass
    run_txn(8'd0,  8'd9,  8'd9,  1'b0, 0, 1'b1, 0);
    run_txn(8'd12, 8'd0,  8'd12, 1'b0, 0, 1'b1, 0);
    // Core never finishes: timeout after TIMEOUT cycles in WAIT
    stuck_done = 1'b1;
    run_txn(8'd5, 8'd3, 8'd0, 1'b1, 2 + TIMEOUT, 1'b0, 0);
    stuck_done = 1'b0;
    // Backpressure with a second pair offered during RESP and CORE_RST
    run_txn(8'd21, 8'd14, 8'd7, 1'b0, 6, 1'b0, 5);

    // Host reset in the middle of WAIT
    in_a     = 8'd48;
    in_b     = 8'd18;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_result", out_result, 0);
    check("midrst_out_err", out_err, 0);
    check("midrst_gcd_data", gcd_data, 0);
    check("midrst_gcd_start", gcd_start, 0);
    check("midrst_gcd_rst_n", gcd_rst_n, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    while (!gcd_rst_n && n < 20) begin
      check("midrst_no_valid", out_valid, 0);
      @(posedge clk); #1;
      n++;
    end
    check("midrst_rst_len", n, RST_CYCLES);
    check("midrst_in_ready_back", in_ready, 1);
    check("midrst_out_valid_back", out_valid, 0);
    $display("mid-WAIT reset recovered after %0d cycles", n);

    // Core works again after the mid-transaction reset
    run_txn(8'd9, 8'd6, 8'd3, 1'b0, 6, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gcd_host_sequencer.md
Name: gcd_host_sequencer

Overview:
Host-side driver for the subtractive GCD core. It accepts operand pairs over a valid/ready input and loads them into the core over the core's single shared data bus: A first, with start asserted, then B. It waits for the core's done, captures the result and returns it over a valid/ready output. Because the core's done state is terminal, the block re-arms the core with a local reset pulse after every transaction.

Parameters:
WIDTH, 8, operand/result width in bits
TIMEOUT, 1024, max cycles in WAIT before aborting with error (>=2)
RST_CYCLES, 2, cycles gcd_rst_n is held low to re-arm the core (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer can accept a pair
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  GCD, or 0 on error
out_err  out  1  core timed out
gcd_data  out  WIDTH  shared operand bus to the core
gcd_start  out  1  start strobe to the core
gcd_rst_n  out  1  active-low reset to the core
gcd_done  in  1  core done
gcd_result  in  WIDTH  core A register (final GCD)

Behaviour:
- Single FSM. States: IDLE, LOAD_A, LOAD_B, WAIT, RESP, CORE_RST.
- Reset (asynchronous):
  - state=CORE_RST, rst counter=RST_CYCLES-1.
  - in_ready=0, out_valid=0, out_result=0, out_err=0.
  - gcd_data=0, gcd_start=0, gcd_rst_n=0.
  - The core is therefore re-armed after every host reset, including a reset mid-transaction; no partial result is ever emitted.
- All outputs decode from registered state/datapath only; no combinational input-to-output paths.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a/in_b.
  - If either operand is 0: go to RESP with out_result=in_a|in_b, out_err=0, bypass flag=1; the core is not touched (the core cannot terminate on 0).
  - Otherwise go to LOAD_A.
- LOAD_A (1 cycle): gcd_data=A, gcd_start=1.
- LOAD_B (1 cycle): gcd_data=B, gcd_start=0. Clear timer. Go to WAIT.
- WAIT:
  - gcd_data=B held, gcd_start=0; timer increments each cycle.
  - gcd_done sampled 1: out_result<=gcd_result, out_err<=0, go to RESP.
  - Else if timer==TIMEOUT-1: out_result<=0, out_err<=1, go to RESP.
  - done and timeout on the same cycle: done wins.
  - gcd_done is ignored in every state except WAIT.
- RESP:
  - out_valid=1; out_result/out_err held stable until out_ready.
  - On handshake: bypass=1 goes to IDLE; otherwise go to CORE_RST with counter=RST_CYCLES-1.
- CORE_RST:
  - gcd_rst_n=0, counter decrements.
  - At 0, go to IDLE; gcd_rst_n=1 from IDLE onward.
- in_ready=1 only in IDLE; exactly one transaction is in flight. out_valid=1 only in RESP.
- Latency, normal path, from input handshake to out_valid: 3 + N cycles, where N = cycles until the core asserts done.
- Timer width: clog2(TIMEOUT+1). The timer saturates and never wraps.

Test Plan:
- Pair (48,18) with a behavioural core model -> gcd_start high 1 cycle with gcd_data=48, next cycle gcd_data=18; out_result=6, out_err=0; then gcd_rst_n low exactly 2 cycles; in_ready returns 1.
- Pair (7,7) -> out_result=7, out_err=0; core done reached through the equal path.
- Pair (0,9) and (12,0) -> out_result=9 then 12, out_err=0; gcd_start never asserted; gcd_rst_n stays 1.
- Core model with done stuck 0, TIMEOUT=16 -> out_valid asserted 16 cycles after entering WAIT; out_err=1, out_result=0; core reset pulse follows.
- Result ready, out_ready held 0 for 5 cycles -> out_valid and out_result stable; in_ready=0 throughout; a second in_valid is not accepted until after CORE_RST.
- rst_n asserted mid-WAIT -> all outputs immediately at reset values, gcd_rst_n=0; after release gcd_rst_n stays low 2 cycles, then in_ready=1; no stale out_valid.
